// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Package : uart_pkg
// Brief   : Shared frame constants and FSM state encodings for the UART port.
// Revision: 1.0
// ============================================================================
package uart_pkg;

    localparam int   DATA_BITS   = 8;
    localparam logic STOP_LEVEL  = 1'b1;
    localparam logic IDLE_LEVEL  = 1'b1;
    localparam logic START_LEVEL = 1'b0;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_t;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_t;

endpackage
`default_nettype wire

// File: rtl/uart_fifo_port_if.sv
`default_nettype none
// ============================================================================
// Interface: uart_fifo_port_if
// Brief    : CPU strobes/data and board serial pins of the UART port.
// Revision : 1.0
// ============================================================================
interface uart_fifo_port_if;
    import uart_pkg::*;

    logic                 uart0_wr;
    logic                 uart0_rd;
    logic [DATA_BITS-1:0] uart_w;
    logic                 uart0_busy;
    logic                 uart0_valid;
    logic [DATA_BITS-1:0] uart0_data;
    logic                 uart_tx;
    logic                 uart_rx;

    modport master (
        output uart0_wr, uart0_rd, uart_w, uart_rx,
        input  uart0_busy, uart0_valid, uart0_data, uart_tx
    );

    modport slave (
        input  uart0_wr, uart0_rd, uart_w, uart_rx,
        output uart0_busy, uart0_valid, uart0_data, uart_tx
    );

endinterface
`default_nettype wire

// File: rtl/uart_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module  : uart_sync_fifo
// Brief   : Single-clock FIFO, first-word-fall-through head (zero when empty).
// Revision: 1.0
// ============================================================================
module uart_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic             o_full,
    output logic             o_empty,
    output logic [WIDTH-1:0] o_head
);

    localparam int             c_AW      = $clog2(DEPTH);
    localparam logic [c_AW:0]  c_PTR_ONE = {{c_AW{1'b0}}, 1'b1};

    logic [c_AW:0]    r_wptr;
    logic [c_AW:0]    r_rptr;
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic             w_do_push;
    logic             w_do_pop;

    assign o_empty = (r_wptr == r_rptr);
    assign o_full  = (r_wptr[c_AW] != r_rptr[c_AW]) &&
                     (r_wptr[c_AW-1:0] == r_rptr[c_AW-1:0]);
    assign o_head  = o_empty ? '0 : r_mem[r_rptr[c_AW-1:0]];

    // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_do_push) r_wptr <= r_wptr + c_PTR_ONE;
            if (w_do_pop)  r_rptr <= r_rptr + c_PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wptr[c_AW-1:0]] <= i_data;
    end

endmodule
`default_nettype wire

// File: rtl/uart_fifo_port.sv
`default_nettype none
// ============================================================================
// Module  : uart_fifo_port
// Brief   : CPU UART port: TX FIFO + 8N1 serializer, RX sync + deserializer + FIFO.
// Config  : UART_LOOPBACK_EN routes the TX line into RX and holds uart_tx high.
// Revision: 1.0
// ============================================================================
module uart_fifo_port
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 104,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic            clk,
    input  logic            reset,
    uart_fifo_port_if.slave cpu
);

    localparam int              c_BW       = $clog2(CLKS_PER_BIT);
    localparam logic [c_BW-1:0] c_BAUD_MAX = c_BW'(CLKS_PER_BIT - 1);
    localparam logic [c_BW-1:0] c_HALF_MAX = c_BW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [c_BW-1:0] c_BAUD_ONE = c_BW'(1);
    localparam logic [2:0]      c_LAST_BIT = 3'(DATA_BITS - 1);

    logic                 w_tx_full, w_tx_empty, w_tx_pop;
    logic [DATA_BITS-1:0] w_tx_head;
    tx_state_t            r_tx_state, w_tx_state_n;
    logic [c_BW-1:0]      r_tx_cnt, w_tx_cnt_n;
    logic [2:0]           r_tx_bit, w_tx_bit_n;
    logic [DATA_BITS-1:0] r_tx_shift, w_tx_shift_n;
    logic                 r_tx_line, w_tx_line_n;

    logic                 w_rx_full, w_rx_empty, w_rx_push, w_rx_in;
    logic [DATA_BITS-1:0] w_rx_head;
    logic                 r_rx_meta, r_rx_sync, r_rx_prev;
    rx_state_t            r_rx_state, w_rx_state_n;
    logic [c_BW-1:0]      r_rx_cnt, w_rx_cnt_n;
    logic [2:0]           r_rx_bit, w_rx_bit_n;
    logic [DATA_BITS-1:0] r_rx_shift, w_rx_shift_n;
    logic                 w_unused;

`ifdef UART_LOOPBACK_EN
    assign w_rx_in     = r_tx_line;
    assign cpu.uart_tx = IDLE_LEVEL;
    assign w_unused    = &{1'b0, w_rx_full, cpu.uart_rx};
`else
    assign w_rx_in     = cpu.uart_rx;
    assign cpu.uart_tx = r_tx_line;
    assign w_unused    = &{1'b0, w_rx_full};
`endif

    uart_sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk    (clk),
        .reset  (reset),
        .i_push (cpu.uart0_wr),
        .i_data (cpu.uart_w),
        .i_pop  (w_tx_pop),
        .o_full (w_tx_full),
        .o_empty(w_tx_empty),
        .o_head (w_tx_head)
    );

    uart_sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk    (clk),
        .reset  (reset),
        .i_push (w_rx_push),
        .i_data (r_rx_shift),
        .i_pop  (cpu.uart0_rd),
        .o_full (w_rx_full),
        .o_empty(w_rx_empty),
        .o_head (w_rx_head)
    );

    assign cpu.uart0_busy  = w_tx_full;
    assign cpu.uart0_valid = !w_rx_empty;
    assign cpu.uart0_data  = w_rx_head;

    // ---------------- TX serializer ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_tx_state <= TX_IDLE;
            r_tx_cnt   <= '0;
            r_tx_bit   <= '0;
            r_tx_shift <= '0;
            r_tx_line  <= IDLE_LEVEL;
        end else begin
            r_tx_state <= w_tx_state_n;
            r_tx_cnt   <= w_tx_cnt_n;
            r_tx_bit   <= w_tx_bit_n;
            r_tx_shift <= w_tx_shift_n;
            r_tx_line  <= w_tx_line_n;
        end
    end

    always_comb begin
        w_tx_state_n = r_tx_state;
        w_tx_cnt_n   = r_tx_cnt + c_BAUD_ONE;
        w_tx_bit_n   = r_tx_bit;
        w_tx_shift_n = r_tx_shift;
        w_tx_line_n  = r_tx_line;
        w_tx_pop     = 1'b0;
        case (r_tx_state)
            TX_IDLE: begin
                w_tx_cnt_n  = '0;
                w_tx_line_n = IDLE_LEVEL;
                if (!w_tx_empty) begin
                    w_tx_pop     = 1'b1;
                    w_tx_state_n = TX_START;
                    w_tx_shift_n = w_tx_head;
                    w_tx_line_n  = START_LEVEL;
                end
            end
            TX_START: begin
                if (r_tx_cnt == c_BAUD_MAX) begin
                    w_tx_cnt_n   = '0;
                    w_tx_bit_n   = '0;
                    w_tx_state_n = TX_DATA;
                    w_tx_line_n  = r_tx_shift[0];
                    w_tx_shift_n = {1'b0, r_tx_shift[DATA_BITS-1:1]};
                end
            end
            TX_DATA: begin
                if (r_tx_cnt == c_BAUD_MAX) begin
                    w_tx_cnt_n = '0;
                    if (r_tx_bit == c_LAST_BIT) begin
                        w_tx_bit_n   = '0;
                        w_tx_state_n = TX_STOP;
                        w_tx_line_n  = STOP_LEVEL;
                    end else begin
                        w_tx_bit_n   = r_tx_bit + 3'd1;
                        w_tx_line_n  = r_tx_shift[0];
                        w_tx_shift_n = {1'b0, r_tx_shift[DATA_BITS-1:1]};
                    end
                end
            end
            TX_STOP: begin
                if (r_tx_cnt == c_BAUD_MAX) begin
                    w_tx_cnt_n = '0;
                    // Chain straight into the next start bit so frames have no gap.
                    if (!w_tx_empty) begin
                        w_tx_pop     = 1'b1;
                        w_tx_state_n = TX_START;
                        w_tx_shift_n = w_tx_head;
                        w_tx_line_n  = START_LEVEL;
                    end else begin
                        w_tx_state_n = TX_IDLE;
                        w_tx_line_n  = IDLE_LEVEL;
                    end
                end
            end
            default: w_tx_state_n = TX_IDLE;
        endcase
    end

    // ---------------- RX synchronizer + deserializer ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rx_meta  <= IDLE_LEVEL;
            r_rx_sync  <= IDLE_LEVEL;
            r_rx_prev  <= IDLE_LEVEL;
            r_rx_state <= RX_IDLE;
            r_rx_cnt   <= '0;
            r_rx_bit   <= '0;
            r_rx_shift <= '0;
        end else begin
            r_rx_meta  <= w_rx_in;
            r_rx_sync  <= r_rx_meta;
            r_rx_prev  <= r_rx_sync;
            r_rx_state <= w_rx_state_n;
            r_rx_cnt   <= w_rx_cnt_n;
            r_rx_bit   <= w_rx_bit_n;
            r_rx_shift <= w_rx_shift_n;
        end
    end

    always_comb begin
        w_rx_state_n = r_rx_state;
        w_rx_cnt_n   = r_rx_cnt + c_BAUD_ONE;
        w_rx_bit_n   = r_rx_bit;
        w_rx_shift_n = r_rx_shift;
        w_rx_push    = 1'b0;
        case (r_rx_state)
            RX_IDLE: begin
                w_rx_cnt_n = '0;
                // The detect cycle counts as the first clock of the half-bit wait.
                if (r_rx_prev && !r_rx_sync) begin
                    w_rx_state_n = RX_START;
                    w_rx_cnt_n   = c_BAUD_ONE;
                end
            end
            RX_START: begin
                if (r_rx_cnt == c_HALF_MAX) begin
                    w_rx_cnt_n   = '0;
                    w_rx_bit_n   = '0;
                    w_rx_state_n = (r_rx_sync == START_LEVEL) ? RX_DATA : RX_IDLE;
                end
            end
            RX_DATA: begin
                if (r_rx_cnt == c_BAUD_MAX) begin
                    w_rx_cnt_n   = '0;
                    w_rx_shift_n = {r_rx_sync, r_rx_shift[DATA_BITS-1:1]};
                    if (r_rx_bit == c_LAST_BIT) begin
                        w_rx_bit_n   = '0;
                        w_rx_state_n = RX_STOP;
                    end else begin
                        w_rx_bit_n = r_rx_bit + 3'd1;
                    end
                end
            end
            RX_STOP: begin
                if (r_rx_cnt == c_BAUD_MAX) begin
                    w_rx_cnt_n   = '0;
                    w_rx_state_n = RX_IDLE;
                    w_rx_push    = (r_rx_sync == STOP_LEVEL);
                end
            end
            default: w_rx_state_n = RX_IDLE;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_fifo_port.sv
`default_nettype none
// ============================================================================
// Module  : tb_uart_fifo_port
// Brief   : Randomized self-checking bench for uart_fifo_port (8 clk/bit, depth 4).
// Revision: 1.0
// ============================================================================
module tb_uart_fifo_port;

    localparam int CPB   = 8;
    localparam int DEPTH = 4;
    localparam int HALF  = CPB / 2;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;

    uart_fifo_port_if u_if ();

    uart_fifo_port #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .clk  (clk),
        .reset(reset),
        .cpu  (u_if.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd_pulse();
        u_if.uart0_rd = 1'b1;
        tick();
        u_if.uart0_rd = 1'b0;
    endtask

    // Expects the start bit to be on the line now; checks all 10 bit slots cycle-exactly.
    task automatic tx_frame_check(input logic [7:0] b);
        logic [9:0] frame;
        logic [7:0] s;
        frame = {1'b1, b, 1'b0};
        for (int slot = 0; slot < 10; slot++) begin
            for (int j = 0; j < CPB; j++) begin
                s[j] = u_if.uart_tx;
                tick();
            end
            check($sformatf("tx_slot%0d_byte%0h", slot, b), 32'(s), frame[slot] ? 32'hFF : 32'h00);
        end
    endtask

    // Independent mid-bit decoder of the uart_tx pin.
    task automatic tx_decode(output logic [7:0] b);
        int waited;
        b = '0;
        waited = 0;
        while (u_if.uart_tx !== 1'b0 && waited < 40 * CPB) begin
            tick();
            waited++;
        end
        if (u_if.uart_tx !== 1'b0) begin
            check("tx_start_timeout", 32'(waited), 32'(0));
            return;
        end
        repeat (HALF) tick();
        check("tx_start_mid", 32'(u_if.uart_tx), 32'(0));
        for (int i = 0; i < 8; i++) begin
            repeat (CPB) tick();
            b[i] = u_if.uart_tx;
        end
        repeat (CPB) tick();
        check("tx_stop_mid", 32'(u_if.uart_tx), 32'(1));
    endtask

    // Drives one 8N1 frame; lat = first clock within the stop bit where valid is seen.
    task automatic rx_drive(input logic [7:0] b, input logic stop, output int lat);
        lat = -1;
        u_if.uart_rx = 1'b0;
        repeat (CPB) tick();
        for (int i = 0; i < 8; i++) begin
            u_if.uart_rx = b[i];
            repeat (CPB) tick();
        end
        u_if.uart_rx = stop;
        for (int k = 1; k <= CPB; k++) begin
            tick();
            if (lat < 0 && u_if.uart0_valid === 1'b1) lat = k;
        end
        u_if.uart_rx = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog n_checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] q[$];
        logic [7:0] b;
        logic [7:0] got;
        logic [15:0] s16;
        int lat;
        int n;

        u_if.uart0_wr = 1'b0;
        u_if.uart0_rd = 1'b0;
        u_if.uart_w   = '0;
        u_if.uart_rx  = 1'b1;
        reset = 1'b1;
        repeat (3) tick();
        check("rst_tx",    32'(u_if.uart_tx),     32'(1));
        check("rst_busy",  32'(u_if.uart0_busy),  32'(0));
        check("rst_valid", 32'(u_if.uart0_valid), 32'(0));
        check("rst_data",  32'(u_if.uart0_data),  32'(0));
        reset = 1'b0;
        repeat (2) tick();

`ifndef UART_LOOPBACK_EN
        // Single byte: start bit appears one edge after the write edge.
        u_if.uart0_wr = 1'b1;
        u_if.uart_w   = 8'hA5;
        tick();
        u_if.uart0_wr = 1'b0;
        check("t1_busy", 32'(u_if.uart0_busy), 32'(0));
        tick();
        tx_frame_check(8'hA5);
        check("t1_idle", 32'(u_if.uart_tx), 32'(1));
        check("t1_busy_end", 32'(u_if.uart0_busy), 32'(0));
        repeat (CPB) tick();

        // Five consecutive writes stream out with no inter-frame gap.
        u_if.uart0_wr = 1'b1;
        u_if.uart_w   = 8'h01;
        tick();
        fork
            begin
                for (int v = 2; v <= 5; v++) begin
                    u_if.uart_w = 8'(v);
                    tick();
                end
                u_if.uart0_wr = 1'b0;
            end
            begin
                tick();
                for (int v = 1; v <= 5; v++) tx_frame_check(8'(v));
            end
        join
        check("t2_idle", 32'(u_if.uart_tx), 32'(1));
        repeat (CPB) tick();

        // Queue five bytes behind an active frame: fourth fills, fifth dropped.
        u_if.uart0_wr = 1'b1;
        u_if.uart_w   = 8'h80;
        tick();
        u_if.uart0_wr = 1'b0;
        fork
            begin
                repeat (20) tick();
                for (int v = 8'h81; v <= 8'h85; v++) begin
                    u_if.uart0_wr = 1'b1;
                    u_if.uart_w   = 8'(v);
                    tick();
                    if (v == 8'h83) check("t2b_busy_3", 32'(u_if.uart0_busy), 32'(0));
                    if (v == 8'h84) check("t2b_busy_4", 32'(u_if.uart0_busy), 32'(1));
                end
                u_if.uart0_wr = 1'b0;
                check("t2b_busy_drop", 32'(u_if.uart0_busy), 32'(1));
            end
            begin
                tick();
                tx_frame_check(8'h80);
                for (int v = 8'h81; v <= 8'h84; v++) tx_frame_check(8'(v));
            end
        join
        for (int j = 0; j < 16; j++) begin
            s16[j] = u_if.uart_tx;
            tick();
        end
        check("t2b_no_fifth", 32'(s16), 32'hFFFF);

        // Random bursts of up to four bytes, decoded independently from the pin.
        for (int r = 0; r < 4; r++) begin
            n = int'($urandom_range(1, 4));
            q.delete();
            for (int i = 0; i < n; i++) begin
                b = 8'($urandom);
                q.push_back(b);
                u_if.uart0_wr = 1'b1;
                u_if.uart_w   = b;
                tick();
            end
            u_if.uart0_wr = 1'b0;
            while (q.size() > 0) begin
                tx_decode(got);
                check($sformatf("tx_rand_r%0d", r), 32'(got), 32'(q[0]));
                void'(q.pop_front());
            end
            repeat (2 * CPB) tick();
        end

        // Reset in the middle of a data bit with a full TX FIFO.
        u_if.uart0_wr = 1'b1;
        u_if.uart_w   = 8'h00;
        tick();
        for (int v = 1; v <= 4; v++) begin
            u_if.uart_w = 8'(v * 17);
            tick();
        end
        u_if.uart0_wr = 1'b0;
        check("t6_busy_full", 32'(u_if.uart0_busy), 32'(1));
        repeat (25) tick();
        check("t6_tx_mid", 32'(u_if.uart_tx), 32'(0));
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("t6_tx_after_rst", 32'(u_if.uart_tx), 32'(1));
        check("t6_busy_after_rst", 32'(u_if.uart0_busy), 32'(0));
        for (int j = 0; j < 16; j++) begin
            s16[j] = u_if.uart_tx;
            tick();
        end
        check("t6_tx_stays_idle", 32'(s16), 32'hFFFF);

        // RX single frame, latency bound and pop.
        rx_drive(8'h3C, 1'b1, lat);
        check("t3_lat_ok", 32'(lat >= 1 && lat <= HALF + 3), 32'(1));
        check("t3_valid", 32'(u_if.uart0_valid), 32'(1));
        check("t3_data",  32'(u_if.uart0_data),  32'h3C);
        rd_pulse();
        check("t3_valid_pop", 32'(u_if.uart0_valid), 32'(0));
        check("t3_data_pop",  32'(u_if.uart0_data),  32'(0));
        rd_pulse();
        check("t3_rd_empty", 32'(u_if.uart0_valid), 32'(0));

        // Glitch and framing error are discarded; a following good frame lands.
        u_if.uart_rx = 1'b0;
        repeat (3) tick();
        u_if.uart_rx = 1'b1;
        repeat (2 * CPB) tick();
        check("t4_glitch", 32'(u_if.uart0_valid), 32'(0));
        rx_drive(8'h55, 1'b0, lat);
        repeat (CPB) tick();
        check("t4_frame_err", 32'(u_if.uart0_valid), 32'(0));
        rx_drive(8'hA7, 1'b1, lat);
        check("t4_recover", 32'(u_if.uart0_data), 32'hA7);
        rd_pulse();

        // Overflow: fifth frame dropped, first four read back in order.
        for (int i = 0; i < 5; i++) rx_drive(8'(16 + i), 1'b1, lat);
        repeat (CPB) tick();
        for (int i = 0; i < 4; i++) begin
            check($sformatf("t5_valid%0d", i), 32'(u_if.uart0_valid), 32'(1));
            check($sformatf("t5_data%0d", i),  32'(u_if.uart0_data),  32'(16 + i));
            rd_pulse();
        end
        check("t5_valid_end", 32'(u_if.uart0_valid), 32'(0));
        check("t5_data_end",  32'(u_if.uart0_data),  32'(0));

        // Random RX rounds against a queue model of a depth-4 FIFO.
        for (int r = 0; r < 6; r++) begin
            n = int'($urandom_range(1, 6));
            q.delete();
            for (int i = 0; i < n; i++) begin
                logic ok;
                b  = 8'($urandom);
                ok = ($urandom_range(0, 9) != 0);
                rx_drive(b, ok, lat);
                if (ok && q.size() < DEPTH) q.push_back(b);
                repeat ($urandom_range(0, 12)) tick();
            end
            repeat (CPB) tick();
            while (q.size() > 0) begin
                check($sformatf("rx_rand_valid_r%0d", r), 32'(u_if.uart0_valid), 32'(1));
                check($sformatf("rx_rand_data_r%0d", r),  32'(u_if.uart0_data),  32'(q[0]));
                void'(q.pop_front());
                rd_pulse();
            end
            check($sformatf("rx_rand_empty_r%0d", r), 32'(u_if.uart0_valid), 32'(0));
        end
`else
        begin
            logic held;
            int   waited;
            held   = 1'b1;
            waited = 0;
            u_if.uart0_wr = 1'b1;
            u_if.uart_w   = 8'h7E;
            tick();
            u_if.uart0_wr = 1'b0;
            while (u_if.uart0_valid !== 1'b1 && waited < 30 * CPB) begin
                if (u_if.uart_tx !== 1'b1) held = 1'b0;
                tick();
                waited++;
            end
            check("lb_valid",   32'(u_if.uart0_valid), 32'(1));
            check("lb_data",    32'(u_if.uart0_data),  32'h7E);
            check("lb_tx_held", 32'(held),             32'(1));
            rd_pulse();
            check("lb_empty",   32'(u_if.uart0_valid), 32'(0));
        end
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
